approx_adder_pipe: RTL and testbench

APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

---
 rtl/approx_adder_pipe.sv | 197 +++++++++++++++++++
 tb/tb_approx_adder_pipe.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_pipe.sv
`default_nettype none
//============================================================================
// Module  : approx_adder_pipe
// Purpose : Two-stage pipelined approximate adder. The low LOW_BITS sum bits
//           come from a rank-RANK compressor (factors f[k]) expanded through
//           basis H. The high part adds the upper operand bits plus a
//           predicted carry. 'exact' bypasses the approximation per
//           transaction.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - operand handshake (a, b, cin, exact)
//           out_valid/out_ready - result handshake (sum, WIDTH+1 bits)
//           err_clr/err_cnt     - mismatch counter clear / saturating count
// Options : APPROX_ERR_MON_EN   - builds the exact-sum error monitor; when
//                                 undefined err_cnt is tied to 0 and
//                                 err_clr is ignored.
// Revision: 1.0 - initial release
//============================================================================
module approx_adder_pipe #(
    parameter int WIDTH    = 32,
    parameter int LOW_BITS = 5,
    parameter int RANK     = 1,
    parameter logic [RANK*LOW_BITS-1:0] MA = '1,
    parameter logic [RANK*LOW_BITS-1:0] MB = '1,
    parameter logic [RANK-1:0]          MC = '1,
    parameter logic [RANK*LOW_BITS-1:0] H  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    input  logic             err_clr,
    output logic [15:0]      err_cnt
);
    localparam int c_HI_W = WIDTH - LOW_BITS;

    // ------------------------------------------------------------------
    // Stage-1 input logic
    // ------------------------------------------------------------------
    logic [RANK-1:0]   w_f;
    logic [LOW_BITS:0] w_lo_exact;
    logic              w_carry;

    for (genvar k = 0; k < RANK; k++) begin : g_factor
        assign w_f[k] = ~((^(a[LOW_BITS-1:0] & MA[k*LOW_BITS +: LOW_BITS])) ^
                          (^(b[LOW_BITS-1:0] & MB[k*LOW_BITS +: LOW_BITS])) ^
                          (cin & MC[k]));
    end

    assign w_lo_exact = {1'b0, a[LOW_BITS-1:0]} + {1'b0, b[LOW_BITS-1:0]} +
                        {{LOW_BITS{1'b0}}, cin};

    // Exact transactions reuse the carry slot for the true low-part carry, so
    // the stage-2 adder yields a+b+cin without a second full-width adder.
    assign w_carry = exact ? w_lo_exact[LOW_BITS] : (a[LOW_BITS-1] & b[LOW_BITS-1]);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              r_s1_valid_q, w_s1_valid_d;
    logic              r_s2_valid_q, w_s2_valid_d;
    logic [WIDTH:0]    r_sum_q,      w_sum_d;
    logic [RANK-1:0]   r_s1_f_q,     w_s1_f_d;
    logic [c_HI_W-1:0] r_s1_ah_q,    w_s1_ah_d;
    logic [c_HI_W-1:0] r_s1_bh_q,    w_s1_bh_d;
    logic              r_s1_carry_q, w_s1_carry_d;
    logic              r_s1_exact_q, w_s1_exact_d;
    logic [LOW_BITS-1:0] r_s1_xlo_q, w_s1_xlo_d;

    logic w_s1_load, w_s2_load, w_s1_take, w_s2_take;

    // Handshake: S2 frees up when empty or draining; S1 when empty or moving on.
    always_comb begin
        w_s2_load    = ~r_s2_valid_q | out_ready;
        w_s1_load    = ~r_s1_valid_q | w_s2_load;
        w_s1_take    = w_s1_load & in_valid;
        w_s2_take    = w_s2_load & r_s1_valid_q;
        w_s1_valid_d = w_s1_load ? in_valid : r_s1_valid_q;
        w_s2_valid_d = w_s2_load ? r_s1_valid_q : r_s2_valid_q;
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid_q;
    assign sum       = r_sum_q;

    always_comb begin
        w_s1_f_d     = r_s1_f_q;
        w_s1_ah_d    = r_s1_ah_q;
        w_s1_bh_d    = r_s1_bh_q;
        w_s1_carry_d = r_s1_carry_q;
        w_s1_exact_d = r_s1_exact_q;
        w_s1_xlo_d   = r_s1_xlo_q;
        if (w_s1_take) begin
            w_s1_f_d     = w_f;
            w_s1_ah_d    = a[WIDTH-1:LOW_BITS];
            w_s1_bh_d    = b[WIDTH-1:LOW_BITS];
            w_s1_carry_d = w_carry;
            w_s1_exact_d = exact;
            w_s1_xlo_d   = w_lo_exact[LOW_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage-2 logic: expansion of factors and high-part addition
    // ------------------------------------------------------------------
    logic [LOW_BITS-1:0] w_lo_approx;
    logic [c_HI_W:0]     w_high;
    logic [WIDTH:0]      w_sum_new;

    always_comb begin
        w_lo_approx = '0;
        for (int k = 0; k < RANK; k++) begin
            w_lo_approx = w_lo_approx |
                          ({LOW_BITS{r_s1_f_q[k]}} & H[k*LOW_BITS +: LOW_BITS]);
        end
        w_high    = {1'b0, r_s1_ah_q} + {1'b0, r_s1_bh_q} + {{c_HI_W{1'b0}}, r_s1_carry_q};
        w_sum_new = {w_high, (r_s1_exact_q ? r_s1_xlo_q : w_lo_approx)};
        w_sum_d   = w_s2_take ? w_sum_new : r_sum_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s2_valid_q <= 1'b0;
            r_sum_q      <= '0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_sum_q      <= w_sum_d;
        end
    end

    // Stage-1 payload only matters while r_s1_valid_q is set.
    always_ff @(posedge clk) begin
        r_s1_f_q     <= w_s1_f_d;
        r_s1_ah_q    <= w_s1_ah_d;
        r_s1_bh_q    <= w_s1_bh_d;
        r_s1_carry_q <= w_s1_carry_d;
        r_s1_exact_q <= w_s1_exact_d;
        r_s1_xlo_q   <= w_s1_xlo_d;
    end

    // ------------------------------------------------------------------
    // Error monitor
    // ------------------------------------------------------------------
`ifdef APPROX_ERR_MON_EN
    logic [WIDTH:0] r_s1_xsum_q, w_s1_xsum_d;
    logic           r_s2_mis_q,  w_s2_mis_d;
    logic [15:0]    r_err_cnt_q, w_err_cnt_d;

    always_comb begin
        w_s1_xsum_d = r_s1_xsum_q;
        if (w_s1_take) begin
            w_s1_xsum_d = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
        w_s2_mis_d = r_s2_mis_q;
        if (w_s2_take) begin
            w_s2_mis_d = (w_sum_new != r_s1_xsum_q);
        end
        // Clear wins over a coincident increment.
        w_err_cnt_d = r_err_cnt_q;
        if (err_clr) begin
            w_err_cnt_d = '0;
        end else if (r_s2_valid_q && out_ready && r_s2_mis_q && (r_err_cnt_q != 16'hFFFF)) begin
            w_err_cnt_d = r_err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_xsum_q <= w_s1_xsum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_mis_q  <= 1'b0;
            r_err_cnt_q <= '0;
        end else begin
            r_s2_mis_q  <= w_s2_mis_d;
            r_err_cnt_q <= w_err_cnt_d;
        end
    end

    assign err_cnt = r_err_cnt_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_cnt          = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe.sv
`default_nettype none
//============================================================================
// Module  : tb_approx_adder_pipe
// Purpose : Self-checking bench for approx_adder_pipe (WIDTH=8, LOW_BITS=2,
//           RANK=1, MA=01, MB=01, MC=1, H=01) against a behavioural model.
// Options : APPROX_ERR_MON_EN - also checks the error counter behaviour.
// Revision: 1.0 - initial release
//============================================================================
module tb_approx_adder_pipe;
    localparam int W  = 8;
    localparam int W1 = W + 1;
    localparam int L  = 2;
    localparam int R  = 1;
    localparam logic [R*L-1:0] MA = 2'b01;
    localparam logic [R*L-1:0] MB = 2'b01;
    localparam logic [R-1:0]   MC = 1'b1;
    localparam logic [R*L-1:0] H  = 2'b01;
`ifdef APPROX_ERR_MON_EN
    localparam bit MON_EN = 1'b1;
`else
    localparam bit MON_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         exact = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   sum;
    logic         err_clr = 1'b0;
    logic [15:0]  err_cnt;

    int errors  = 0;
    int checks  = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    approx_adder_pipe #(
        .WIDTH(W), .LOW_BITS(L), .RANK(R), .MA(MA), .MB(MB), .MC(MC), .H(H)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .exact(exact),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: arithmetic straight from the factor/expansion/carry rules.
    function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input logic e);
        int lo, hi, f;
        if (e) return W1'(int'(x) + int'(y) + int'(c));
        lo = 0;
        for (int k = 0; k < R; k++) begin
            f = 1 ^ ($countones(x[L-1:0] & MA[k*L +: L]) % 2)
                  ^ ($countones(y[L-1:0] & MB[k*L +: L]) % 2)
                  ^ int'(c & MC[k]);
            for (int j = 0; j < L; j++)
                if (f == 1 && H[k*L+j]) lo = lo | (1 << j);
        end
        hi = (int'(x) >> L) + (int'(y) >> L) + int'(x[L-1] & y[L-1]);
        return W1'(hi * (1 << L) + lo);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic bit is_mismatch(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic e);
        return model_sum(x, y, c, e) != model_sum(x, y, c, 1'b1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends one transaction into an empty pipeline; returns observed sum and
    // the number of cycles from acceptance to out_valid (10 = timed out).
    task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic te,
                            output logic [W:0] got, output int lat);
        a = ta; b = tb_; cin = tc; exact = te; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            tick;
            lat++;
        end
        got = sum;
        if (is_mismatch(ta, tb_, tc, te)) exp_err = sat_inc(exp_err);
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 000", sum); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0000", err_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        exp_err = 0;
        tick;
    endtask

    task automatic test_directed;
        logic [W-1:0] va [5] = '{8'h03, 8'h05, 8'h05, 8'hFF, 8'hFF};
        logic [W-1:0] vb [5] = '{8'h01, 8'h02, 8'h02, 8'hFF, 8'hFF};
        logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         ve [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // Last entry: factor is 0 and the predicted carry is 1, so the sum is
        // (3F+3F+1) over low bits 00.
        logic [W:0]   vs [5] = '{9'h001, 9'h004, 9'h007, 9'h1FF, 9'h1FC};
        logic [W:0]   got;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            send_one(va[i], vb[i], vc[i], ve[i], got, lat);
            checks++;
            if (got !== vs[i]) begin
                errors++;
                $display("FAIL directed_sum[%0d]: got %h expected %h", i, got, vs[i]);
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 2", i, lat);
            end
            checks++;
            if (err_cnt !== (MON_EN ? 16'(exp_err) : 16'd0)) begin
                errors++;
                $display("FAIL directed_err_cnt[%0d]: got %0d expected %0d", i, err_cnt,
                         MON_EN ? exp_err : 0);
            end
        end
    endtask

    task automatic test_random_single;
        logic [W-1:0] ra, rb;
        logic         rc, re;
        logic [W:0]   got, expv;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); re = ($urandom_range(0, 3) == 0);
            expv = model_sum(ra, rb, rc, re);
            send_one(ra, rb, rc, re, got, lat);
            checks++;
            if (got !== expv || lat != 2) begin
                errors++;
                $display("FAIL random_single[%0d]: got %h lat %0d expected %h lat 2", i, got, lat, expv);
            end
        end
    endtask

    task automatic test_stall_stream;
        logic [W:0] q_sum [$];
        bit         q_mis [$];
        bit         pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W:0] held = '0;
        bit         hold_pend = 1'b0;
        logic       exp_ir;
        int         sent = 0, rcvd = 0, cyc = 0;
        while (rcvd < 16 && cyc < 200) begin
            out_ready = pattern[cyc % 4];
            in_valid  = (sent < 16);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); exact = ($urandom_range(0, 3) == 0);
            #1;
            if (hold_pend) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held) begin
                    errors++;
                    $display("FAIL stream_hold: got valid %b sum %h expected valid 1 sum %h", out_valid, sum, held);
                end
            end
            exp_ir = !(q_sum.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_ir) begin
                errors++;
                $display("FAIL stream_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ir);
            end
            checks++;
            if (err_cnt !== (MON_EN ? 16'(exp_err) : 16'd0)) begin
                errors++;
                $display("FAIL stream_err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, MON_EN ? exp_err : 0);
            end
            if (in_valid && in_ready) begin
                q_sum.push_back(model_sum(a, b, cin, exact));
                q_mis.push_back(is_mismatch(a, b, cin, exact));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_sum.size() == 0 || sum !== q_sum[0]) begin
                    errors++;
                    $display("FAIL stream_sum[%0d]: got %h expected %h", rcvd, sum,
                             (q_sum.size() == 0) ? 9'h000 : q_sum[0]);
                end
                if (q_sum.size() != 0) begin
                    if (q_mis[0]) exp_err = sat_inc(exp_err);
                    void'(q_sum.pop_front());
                    void'(q_mis.pop_front());
                end
                rcvd++;
            end
            hold_pend = out_valid && !out_ready;
            held      = sum;
            tick;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (rcvd != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 16", rcvd);
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] q_sum [$];
        int         q_cyc [$];
        bit         q_mis [$];
        int         sent = 0, rcvd = 0, cyc = 0;
        out_ready = 1'b1;
        while (rcvd < 20 && cyc < 100) begin
            in_valid = (sent < 20);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); exact = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, in_ready);
            end
            if (in_valid && in_ready) begin
                q_sum.push_back(model_sum(a, b, cin, exact));
                q_mis.push_back(is_mismatch(a, b, cin, exact));
                q_cyc.push_back(cyc);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_sum.size() == 0 || sum !== q_sum[0] || cyc != q_cyc[0] + 2) begin
                    errors++;
                    $display("FAIL b2b_sum[%0d]: got %h at cyc %0d expected %h at cyc %0d", rcvd, sum, cyc,
                             (q_sum.size() == 0) ? 9'h000 : q_sum[0], (q_cyc.size() == 0) ? -1 : q_cyc[0] + 2);
                end
                if (q_sum.size() != 0) begin
                    if (q_mis[0]) exp_err = sat_inc(exp_err);
                    void'(q_sum.pop_front());
                    void'(q_mis.pop_front());
                    void'(q_cyc.pop_front());
                end
                rcvd++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != 20) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 20", rcvd);
        end
        checks++;
        if (err_cnt !== (MON_EN ? 16'(exp_err) : 16'd0)) begin
            errors++;
            $display("FAIL b2b_err_cnt: got %0d expected %0d", err_cnt, MON_EN ? exp_err : 0);
        end
    endtask

    task automatic test_mid_reset;
        logic [W:0] got;
        int         lat, seen;
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0; exact = 1'b0;
        a = 8'h03; b = 8'h01;
        tick;
        a = 8'h05; b = 8'h02;
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_inflight: got %b expected 1", out_valid);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_err = 0;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: got valid %b err %0d ready %b expected 0 0 1", out_valid, err_cnt, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) seen++;
            tick;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_discard: got %0d valid cycles expected 0", seen);
        end
        send_one(8'h05, 8'h02, 1'b0, 1'b1, got, lat);
        checks++;
        if (got !== 9'h007 || lat != 2) begin
            errors++;
            $display("FAIL mid_reset_next: got %h lat %0d expected 007 lat 2", got, lat);
        end
    endtask

    task automatic test_err_monitor;
        logic [W:0] got;
        int         lat;
`ifdef APPROX_ERR_MON_EN
        a = 8'h03; b = 8'h01; cin = 1'b0; exact = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) tick;
        in_valid = 1'b0;
        tick; tick; tick;
        exp_err = 65535;
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_saturate: got %h expected FFFF", err_cnt);
        end
        send_one(8'h03, 8'h01, 1'b0, 1'b0, got, lat);
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_hold_max: got %h expected FFFF", err_cnt);
        end
        a = 8'h03; b = 8'h01; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_setup: got valid %b expected 1", out_valid);
        end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        exp_err = 0;
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL err_clr_priority: got %h expected 0000", err_cnt);
        end
`else
        err_clr = 1'b1;
        send_one(8'h03, 8'h01, 1'b0, 1'b0, got, lat);
        err_clr = 1'b0;
        send_one(8'h03, 8'h01, 1'b0, 1'b0, got, lat);
        checks++;
        if (err_cnt !== 16'd0 || got !== 9'h001) begin
            errors++;
            $display("FAIL err_tied_off: got err %h sum %h expected 0000 001", err_cnt, got);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random_single;
        test_stall_stream;
        test_back_to_back;
        test_mid_reset;
        test_err_monitor;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
